uart_mem_loader: RTL and testbench

Parametrised successor to the fixed 21-bit program loader. It receives framed commands over an 8N1 UART and drives a byte-wide external memory write port, selected by `enable` while the CPU is held in reset. It adds a configurable address width, write-pulse width and baud divider, plus a fill mode, per-frame checksum, timeout and error reporting. Its outputs are muxed onto the board address, data and `n_write` pins by the top level.

---
 rtl/uart_mem_loader_pkg.sv | 27 ++
 rtl/uart_mem_loader_rx.sv | 69 ++++++
 rtl/uart_mem_loader.sv | 210 +++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_loader_pkg.sv
// Shared constants for the UART memory loader: command bytes, FSM state codes
// and the bit positions of the sticky error flags.
package uart_mem_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_FILL  = 8'h46;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADR      = 4'd1;
    localparam logic [3:0] S_LEN      = 4'd2;
    localparam logic [3:0] S_PAYLOAD  = 4'd3;
    localparam logic [3:0] S_CSUM     = 4'd4;
    localparam logic [3:0] S_WR_SETUP = 4'd5;
    localparam logic [3:0] S_WR_PULSE = 4'd6;
    localparam logic [3:0] S_WR_HOLD  = 4'd7;
    localparam logic [3:0] S_FILL     = 4'd8;

    localparam int ERR_FRAMING = 0;
    localparam int ERR_CSUM    = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_OVERRUN = 3;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_FILL);
    endfunction

endpackage

// File: rtl/uart_mem_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, falling-edge start detect, mid-bit
// sampling. Emits a one-cycle valid with the byte, or frame_err on a low stop bit.
module uart_rx_8n1 #(
    parameter int CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLK_DIV);

    logic          rx_m, rx_s, rx_d;
    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shift;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_d      <= 1'b1;
            active    <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            rx_d      <= rx_s;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (!active) begin
                if (rx_d && !rx_s) begin
                    active  <= 1'b1;
                    cnt     <= CW'(CLK_DIV / 2 - 1);
                    bit_idx <= '0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt     <= CW'(CLK_DIV - 1);
                bit_idx <= bit_idx + 1'b1;
                // bit 0 is the start bit: high at mid-bit means a glitch, not a frame
                if (bit_idx == 4'd0) begin
                    if (rx_s) active <= 1'b0;
                end else if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                    if (rx_s) begin
                        valid   <= 1'b1;
                        rx_byte <= shift;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    shift <= {rx_s, shift[7:1]};
                end
            end
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Frame parser and byte-wide memory write sequencer fed by a UART receiver.
// Handles 'W' (streamed write) and 'F' (fill) frames with checksum and timeout.
//
// state      | meaning
// IDLE       | waiting for a CMD byte
// ADR        | collecting address bytes, MSB first
// LEN        | collecting LEN_H then LEN_L
// PAYLOAD    | waiting for a data byte ('W') or the fill value ('F')
// CSUM       | waiting for the checksum byte
// WR_SETUP   | 'W' write: adr/data driven, write low
// FILL       | 'F' write: adr/data driven, write low
// WR_PULSE   | write high for WR_CYCLES cycles
// WR_HOLD    | write low, adr stable, then advance
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int ADR_W     = 21,
    parameter int CLK_DIV   = 104,
    parameter int WR_CYCLES = 2,
    parameter int TIMEOUT   = 16 * 10 * CLK_DIV
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             enable,
    input  logic             rx,
    output logic [ADR_W-1:0] adr,
    output logic [7:0]       data,
    output logic             write,
    output logic             busy,
    output logic             done,
    output logic [3:0]       err
);

    localparam int AB = (ADR_W + 7) / 8;
    localparam int BW = (AB > 1) ? $clog2(AB) : 1;
    localparam int PW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [7:0]       rx_byte;
    logic             rx_valid, rx_ferr;
    logic [3:0]       state;
    logic             cmd_fill, len_first, abort, pend;
    logic [7:0]       sum, hold;
    logic [15:0]      cnt;
    logic [BW-1:0]    ab_cnt;
    logic [PW-1:0]    pcnt;
    logic [TW-1:0]    tmr;

    logic             in_valid, waiting, fill_busy, wr_capture;
    logic [7:0]       in_byte, sum_next;
    logic [ADR_W+7:0] adr_shift;

    uart_rx_8n1 #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk       (clk),
        .n_reset   (n_reset),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .valid     (rx_valid),
        .frame_err (rx_ferr)
    );

    // A byte parked while a 'W' write was running is consumed ahead of new ones.
    assign in_valid   = rx_valid | pend;
    assign in_byte    = pend ? hold : rx_byte;
    assign sum_next   = sum + in_byte;
    assign adr_shift  = {adr, in_byte};
    assign waiting    = (state == S_ADR) || (state == S_LEN) ||
                        (state == S_PAYLOAD) || (state == S_CSUM);
    assign fill_busy  = cmd_fill && ((state == S_FILL) || (state == S_WR_PULSE) ||
                                     (state == S_WR_HOLD));
    assign wr_capture = !cmd_fill && rx_valid &&
                        ((state == S_WR_SETUP) || (state == S_WR_PULSE) ||
                         (state == S_WR_HOLD));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= S_IDLE;
            cmd_fill  <= 1'b0;
            len_first <= 1'b0;
            abort     <= 1'b0;
            pend      <= 1'b0;
            sum       <= '0;
            hold      <= '0;
            cnt       <= '0;
            ab_cnt    <= '0;
            pcnt      <= '0;
            tmr       <= TW'(TIMEOUT);
            adr       <= '0;
            data      <= '0;
            write     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= '0;
        end else if (!enable) begin
            state <= S_IDLE;
            write <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pend  <= 1'b0;
            abort <= 1'b0;
            tmr   <= TW'(TIMEOUT);
        end else begin
            done <= 1'b0;
            tmr  <= (waiting && !in_valid) ? tmr - 1'b1 : TW'(TIMEOUT);
            if (waiting) pend <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_valid && is_cmd(rx_byte)) begin
                        err       <= '0;
                        busy      <= 1'b1;
                        sum       <= rx_byte;
                        cmd_fill  <= (rx_byte == CMD_FILL);
                        ab_cnt    <= BW'(AB - 1);
                        len_first <= 1'b1;
                        abort     <= 1'b0;
                        state     <= S_ADR;
                    end
                end
                S_ADR, S_LEN, S_PAYLOAD, S_CSUM: begin
                    if (in_valid) begin
                        sum <= sum_next;
                        if (state == S_ADR) begin
                            adr <= adr_shift[ADR_W-1:0];
                            if (ab_cnt == '0) state <= S_LEN;
                            else ab_cnt <= ab_cnt - 1'b1;
                        end else if (state == S_LEN) begin
                            len_first <= 1'b0;
                            if (len_first) cnt[15:8] <= in_byte;
                            else begin
                                cnt[7:0] <= in_byte;
                                state    <= S_PAYLOAD;
                            end
                        end else if (state == S_PAYLOAD) begin
                            data  <= in_byte;
                            state <= cmd_fill ? S_CSUM : S_WR_SETUP;
                        end else if (sum_next == 8'h00) begin
                            if (cmd_fill) state <= S_FILL;
                            else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end else begin
                            err[ERR_CSUM] <= 1'b1;
                            busy          <= 1'b0;
                            state         <= S_IDLE;
                        end
                    end else if (tmr == '0) begin
                        err[ERR_TIMEOUT] <= 1'b1;
                        busy             <= 1'b0;
                        state            <= S_IDLE;
                    end
                end
                S_WR_SETUP, S_FILL: begin
                    write <= 1'b1;
                    pcnt  <= PW'(WR_CYCLES - 1);
                    state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (pcnt == '0) begin
                        write <= 1'b0;
                        state <= S_WR_HOLD;
                    end else begin
                        pcnt <= pcnt - 1'b1;
                    end
                end
                S_WR_HOLD: begin
                    adr <= adr + 1'b1;
                    if (abort) begin
                        abort <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt == 16'd0) begin
                        if (cmd_fill) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_CSUM;
                        end
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= cmd_fill ? S_FILL : S_PAYLOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (wr_capture) begin
                hold <= rx_byte;
                pend <= 1'b1;
                if (pend) err[ERR_OVERRUN] <= 1'b1;
            end
            if (fill_busy && rx_valid) err[ERR_OVERRUN] <= 1'b1;

            // A pulse already on the bus is allowed to finish before aborting.
            if (rx_ferr) begin
                err[ERR_FRAMING] <= 1'b1;
                if (state == S_WR_PULSE) abort <= 1'b1;
                else if (state != S_IDLE) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    write <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: expected writes are queued as frames are
// sent, and a monitor pops and compares them on every rising write strobe.
module tb_uart_mem_loader;

    localparam int ADR_W     = 21;
    localparam int CLK_DIV   = 8;
    localparam int WR_CYCLES = 2;
    localparam int TIMEOUT   = 16 * 10 * CLK_DIV;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             enable = 1'b0;
    logic             rx = 1'b1;
    logic [ADR_W-1:0] adr;
    logic [7:0]       data;
    logic             write, busy, done;
    logic [3:0]       err;

    uart_mem_loader #(
        .ADR_W(ADR_W), .CLK_DIV(CLK_DIV), .WR_CYCLES(WR_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .n_reset(n_reset), .enable(enable), .rx(rx),
        .adr(adr), .data(data), .write(write), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADR_W-1:0] a;
        logic [7:0]       d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    int         cyc = 0;
    int         last_rise = -1;
    int         plen = 0;
    bit         gap_chk = 1'b0;
    bit         pulse_chk = 1'b1;
    logic       write_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        cyc++;
        if (n_reset && write && !write_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got adr=%0h data=%0h exp=none", adr, data);
            end else begin
                e = exp_q.pop_front();
                chk("write_adr", 32'(adr), 32'(e.a));
                chk("write_data", 32'(data), 32'(e.d));
            end
            if (gap_chk && last_rise >= 0) chk("fill_gap", 32'(cyc - last_rise), WR_CYCLES + 2);
            last_rise = cyc;
            plen = 0;
        end
        if (write) plen++;
        if (!write && write_q && pulse_chk) chk("pulse_width", 32'(plen), WR_CYCLES);
        write_q = write;
        if (done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        rx = 1'b0;
        repeat (CLK_DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(posedge clk);
        end
        rx = stop_ok;
        repeat (CLK_DIV) @(posedge clk);
        rx = 1'b1;
        repeat (CLK_DIV) @(posedge clk);
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i]);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got busy=%0b pending=%0d exp idle", name, busy, exp_q.size());
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog got=running exp=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_adr", 32'(adr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_ctrl", {29'd0, write, busy, done}, 0);
        chk("rst_err", 32'(err), 0);
        n_reset = 1'b1;
        enable  = 1'b1;
        repeat (5) @(posedge clk);

        // 'W' three bytes at 0x012345
        exp_q.push_back({21'h012345, 8'hAA});
        exp_q.push_back({21'h012346, 8'hBB});
        exp_q.push_back({21'h012347, 8'hCC});
        tx_q = {8'h57, 8'h01, 8'h23, 8'h45, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h0D};
        send_q();
        exp_done++;
        wait_idle("w3");
        chk("w3_done", 32'(done_cnt), 32'(exp_done));
        chk("w3_err", 32'(err), 0);

        // enable low: a complete frame must be ignored
        enable = 1'b0;
        tx_q = {8'h57, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h42, 8'h64};
        send_q();
        wait_idle("dis");
        chk("dis_done", 32'(done_cnt), 32'(exp_done));
        chk("dis_busy", 32'(busy), 0);
        enable = 1'b1;
        repeat (4) @(posedge clk);

        // 'F' wrapping at the top of the 21-bit space
        exp_q.push_back({21'h1FFFFF, 8'h5A});
        exp_q.push_back({21'h000000, 8'h5A});
        exp_q.push_back({21'h000001, 8'h5A});
        exp_q.push_back({21'h000002, 8'h5A});
        last_rise = -1;
        gap_chk   = 1'b1;
        tx_q = {8'h46, 8'h1F, 8'hFF, 8'hFF, 8'h00, 8'h03, 8'h5A, 8'h40};
        send_q();
        exp_done++;
        wait_idle("fwrap");
        gap_chk = 1'b0;
        chk("fwrap_done", 32'(done_cnt), 32'(exp_done));
        chk("fwrap_err", 32'(err), 0);

        // 'F' with checksum off by one: no writes, no done
        tx_q = {8'h46, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'hA9};
        send_q();
        wait_idle("badcs");
        chk("badcs_err", 32'(err), 4'b0010);
        chk("badcs_done", 32'(done_cnt), 32'(exp_done));

        exp_q.push_back({21'h000010, 8'h77});
        tx_q = {8'h57, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h77, 8'h22};
        send_q();
        exp_done++;
        wait_idle("clr");
        chk("clr_err", 32'(err), 0);
        chk("clr_done", 32'(done_cnt), 32'(exp_done));

        // framing error on the second address byte
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h23, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("frm_err", 32'(err), 4'b0001);
        chk("frm_busy", 32'(busy), 0);
        send_byte(8'h13);
        repeat (4) @(posedge clk);
        #1;
        chk("junk_err", 32'(err), 4'b0001);
        chk("junk_busy", 32'(busy), 0);
        exp_q.push_back({21'h012345, 8'hAA});
        exp_q.push_back({21'h012346, 8'hBB});
        exp_q.push_back({21'h012347, 8'hCC});
        tx_q = {8'h57, 8'h01, 8'h23, 8'h45, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'h0D};
        send_q();
        exp_done++;
        wait_idle("rec");
        chk("rec_err", 32'(err), 0);
        chk("rec_done", 32'(done_cnt), 32'(exp_done));

        // stall after LEN_L
        tx_q = {8'h57, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
        send_q();
        #1;
        chk("to_busy_before", 32'(busy), 1);
        repeat (TIMEOUT + 200) @(posedge clk);
        #1;
        chk("to_err", 32'(err), 4'b0100);
        chk("to_busy_after", 32'(busy), 0);

        // 64-byte fill with a byte arriving mid-fill
        for (int i = 0; i < 64; i++) exp_q.push_back({21'(32'h200 + i), 8'h3C});
        last_rise = -1;
        gap_chk   = 1'b1;
        tx_q = {8'h46, 8'h00, 8'h02, 8'h00, 8'h00, 8'h3F, 8'h3C, 8'h3D};
        send_q();
        send_byte(8'h55);
        exp_done++;
        wait_idle("ovr");
        gap_chk = 1'b0;
        chk("ovr_err", 32'(err), 4'b1000);
        chk("ovr_done", 32'(done_cnt), 32'(exp_done));

        // reset asserted while write is high
        tx_q = {8'h57, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
        send_q();
        exp_q.push_back({21'h000400, 8'h99});
        fork
            send_byte(8'h99);
        join_none
        n = 0;
        while (!write && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rst_pulse_seen", 32'(write), 1);
        #2;
        pulse_chk = 1'b0;
        n_reset   = 1'b0;
        #1;
        chk("arst_write", 32'(write), 0);
        chk("arst_adr", 32'(adr), 0);
        chk("arst_data", 32'(data), 0);
        chk("arst_ctrl", {30'd0, busy, done}, 0);
        chk("arst_err", 32'(err), 0);
        repeat (40) @(posedge clk);
        n_reset = 1'b1;
        repeat (4) @(posedge clk);
        pulse_chk = 1'b1;
        #1;
        chk("leftover", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
